// File: rtl/nibble_serial_adder.sv
// Serial W-bit adder: feeds one nibble pair per cycle (LSB first) through a
// 4-bit carry-skip slice, rippling the nibble carry through a register.

module carryskipadder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      c[i+1] = (a[i] & b[i]) | (p[i] & c[i]);
    end
    sum  = p ^ c[3:0];
    // When every bit propagates, the carry-in skips straight to the output.
    cout = (&p) ? cin : c[4];
  end

endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  sa_q, sa_d;
  logic [W-1:0]  sb_q, sb_d;
  logic          c_q, c_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [3:0]    slice_sum;
  logic          slice_cout;
  logic [W+3:0]  sum_fill;
  logic          load;

  carryskipadder u_slice (
    .a    (sa_q[3:0]),
    .b    (sb_q[3:0]),
    .cin  (c_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // New nibble enters at the top so after NIBBLES shifts it sits LSB-aligned.
  assign sum_fill = {slice_sum, sum_q};
  assign load     = start && (state_q == IDLE || state_q == DONE);

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      RUN: begin
        sum_d = sum_fill[W+3:4];
        sa_d  = sa_q >> 4;
        sb_d  = sb_q >> 4;
        c_d   = slice_cout;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          cout_d  = slice_cout;
          cnt_d   = '0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Accepted start overrides the IDLE/DONE defaults, giving back-to-back runs.
    if (load) begin
      state_d = RUN;
      sa_d    = a;
      sb_d    = b;
      c_d     = cin;
      cnt_d   = '0;
      sum_d   = '0;
    end

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
